// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and decode helper for the instruction/data
// memory responder.
//   word_t        - one 64-bit memory word
//   resp_t        - one response record {data, err}
//   WORD_BYTES    - bytes per word (width of the write strobe)
//   ADDR_LSB      - byte-address bits below the word index
//   addr_in_range - true when a byte address falls inside [base, base+depth words)
package imem_pkg;

  localparam int WORD_BYTES = 8;
  localparam int ADDR_LSB   = 3;

  typedef logic [63:0] word_t;

  typedef struct packed {
    word_t data;
    logic  err;
  } resp_t;

  // Unsigned 64-bit subtraction: addresses below the base wrap to huge
  // offsets and therefore land out of range without a separate compare.
  function automatic logic addr_in_range(input word_t addr, input word_t base,
                                         input word_t depth);
    word_t offset;
    offset = addr - base;
    return (offset >> ADDR_LSB) < depth;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: request/response bus between the core's memory initiator
// (master) and the memory responder (slave).
//   req_valid/req_ready   request handshake
//   req_addr/we/wdata/wstrb  request payload (byte address, write flag, data, byte enables)
//   resp_valid/resp_ready response handshake
//   resp_data/resp_err    response payload
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid && ready are both 1. The sender keeps valid and payload
// stable until that edge; ready may be asserted independently of valid.
interface imem_responder_if;
  import imem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  word_t                 req_addr;
  logic                  req_we;
  word_t                 req_wdata;
  logic [WORD_BYTES-1:0] req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  word_t                 resp_data;
  logic                  resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/imem_resp_fifo.sv
// imem_resp_fifo: show-ahead FIFO of resp_t records.
//   clk, rst      clock, asynchronous active-low reset
//   push, din     write one entry (ignored when full unless popping the same cycle)
//   pop           consume the head entry (ignored when empty)
//   dout          head entry whenever not empty, zero when empty
//   full, empty   occupancy flags derived from count
//   count         number of stored entries (0..DEPTH)
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  resp_t            din,
  input  logic             pop,
  output resp_t            dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  resp_t            store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  // No bypass: an entry pushed into an empty FIFO shows up one edge later.
  assign dout = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: memory-side responder for the core's fetch/load port.
// Serves 64-bit word reads and byte-masked writes from an internal array,
// returning one response per request, in order, LATENCY cycles after accept
// at the earliest.
//   clk, rst  clock, asynchronous active-low reset
//   bus       imem_responder_if.slave (request and response channels)
//   stat_reads/stat_writes/stat_errs  64-bit accepted-request counters,
//             present only when IMEM_RESPONDER_STATS_EN is defined
// Parameters: BASE_ADDR (byte address of word 0), DEPTH (words, power of 2),
// LATENCY (1..8), FIFO_DEPTH (response entries = request credit, power of 2, >= 2).
module imem_responder
  import imem_pkg::*;
#(
  parameter word_t BASE_ADDR  = 64'h1000,
  parameter int    DEPTH      = 1024,
  parameter int    LATENCY    = 2,
  parameter int    FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  imem_responder_if.slave bus
`ifdef IMEM_RESPONDER_STATS_EN
  ,
  output word_t           stat_reads,
  output word_t           stat_writes,
  output word_t           stat_errs
`endif
);

  localparam int               IDX_W  = $clog2(DEPTH);
  localparam int               CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CREDIT = CNT_W'(FIFO_DEPTH);

  word_t            mem [DEPTH];
  logic             req_ready_q;
  logic             accept;
  logic             consume;
  logic             dec_err;
  logic [IDX_W-1:0] idx;
  word_t            rd_word;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic             pipe_v [LATENCY];
  resp_t            pipe_d [LATENCY];
  resp_t            head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign accept  = bus.req_valid && req_ready_q;
  assign consume = !fifo_empty && bus.resp_ready;

  // Decode at accept.
  assign idx     = IDX_W'((bus.req_addr - BASE_ADDR) >> ADDR_LSB);
  assign dec_err = (bus.req_addr[ADDR_LSB-1:0] != '0)
                || !addr_in_range(bus.req_addr, BASE_ADDR, word_t'(DEPTH));

  // Writes and errors answer with zero data.
  assign rd_word = (accept && !bus.req_we && !dec_err) ? mem[idx] : '0;

  // Array: written at the accept edge, so a read accepted on the next edge
  // already sees the new bytes.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !dec_err) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (bus.req_wstrb[b]) mem[idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
      end
    end
  end

  // Fixed-latency pipeline; it never stalls because the credit limit
  // guarantees the FIFO has room for everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_v[s] <= 1'b0;
        pipe_d[s] <= '0;
      end
    end else begin
      pipe_v[0]      <= accept;
      pipe_d[0].data <= rd_word;
      pipe_d[0].err  <= accept && dec_err;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_d[s] <= pipe_d[s-1];
      end
    end
  end

  // Credit: requests in the pipeline plus entries in the FIFO.
  always_comb begin
    outstanding_nxt = outstanding;
    case ({accept, consume})
      2'b10:   outstanding_nxt = outstanding + CNT_W'(1);
      2'b01:   outstanding_nxt = outstanding - CNT_W'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  // req_ready is registered from the count it will have after this edge, so
  // it drops on the same edge that takes the last credit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      req_ready_q <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      req_ready_q <= (outstanding_nxt < CREDIT);
    end
  end

  imem_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pipe_v[LATENCY-1]),
    .din   (pipe_d[LATENCY-1]),
    .pop   (bus.resp_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = !fifo_empty;
  assign bus.resp_data  = head.data;
  assign bus.resp_err   = head.err;

  // The credit scheme must make overflow impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_full && pipe_v[LATENCY-1] && !bus.resp_ready));
  a_fifo_within_credit: assert property (@(posedge clk) disable iff (!rst)
    fifo_count <= outstanding);

`ifdef IMEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_errs   <= '0;
    end else if (accept) begin
      if (dec_err)          stat_errs   <= stat_errs + 64'd1;
      else if (bus.req_we)  stat_writes <= stat_writes + 64'd1;
      else                  stat_reads  <= stat_reads + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: self-checking bench for imem_responder.
// Requests are driven by tasks; an independent memory model computes each
// expected response when the request is accepted and queues it; responses are
// popped and compared as the DUT hands them over.
module tb_imem_responder;
  import imem_pkg::*;

  localparam word_t BASE   = 64'h1000;
  localparam int    DEPTH  = 1024;
  localparam int    FDEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_responder_if bus();

`ifdef IMEM_RESPONDER_STATS_EN
  word_t stat_reads, stat_writes, stat_errs;
`endif

  imem_responder #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(2), .FIFO_DEPTH(FDEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IMEM_RESPONDER_STATS_EN
    ,
    .stat_reads(stat_reads),
    .stat_writes(stat_writes),
    .stat_errs(stat_errs)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];
  int          acc_q[$];
  word_t       model [int];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          resp_cnt = 0;
  int          ready_drops = 0;
  int          last_lat = 0;
  int          min_lat = 1000;
  int          max_lat = 0;
  int          exp_reads = 0;
  int          exp_writes = 0;
  int          exp_errs = 0;
  logic [64:0] last_resp = '0;
  logic [64:0] mon_exp;
  int          mon_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic word_t pat(input int w);
    return {32'(w) ^ 32'hC0DE_0000, ~32'(w)};
  endfunction

  // Reference model: applied once per accepted request, in accept order.
  function automatic logic [64:0] apply_req(input word_t addr, input logic we,
                                            input word_t wdata, input logic [7:0] wstrb);
    int    w;
    word_t cur;
    if (addr[2:0] != 3'd0 || addr < BASE || addr >= BASE + 64'(DEPTH * 8)) begin
      exp_errs++;
      return {64'd0, 1'b1};
    end
    w   = int'((addr - BASE) >> 3);
    cur = model.exists(w) ? model[w] : 64'd0;
    if (we) begin
      for (int b = 0; b < 8; b++) if (wstrb[b]) cur[b*8 +: 8] = wdata[b*8 +: 8];
      model[w] = cur;
      exp_writes++;
      return 65'd0;
    end
    exp_reads++;
    return {cur, 1'b0};
  endfunction

  // Monitor: samples on the falling edge, between input updates.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(apply_req(bus.req_addr, bus.req_we, bus.req_wdata, bus.req_wstrb));
        acc_q.push_back(cyc + 1);
        acc_cnt++;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          check("stale_resp", 65'(bus.resp_valid), 65'd0);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_acc  = acc_q.pop_front();
          last_lat = cyc - mon_acc;
          if (last_lat < min_lat) min_lat = last_lat;
          if (last_lat > max_lat) max_lat = last_lat;
          last_resp = {bus.resp_data, bus.resp_err};
          check("resp", last_resp, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input word_t addr, input logic we, input word_t wdata,
                        input logic [7:0] wstrb);
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    @(negedge clk);
    while (!bus.req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check("req_accept_timeout", 65'(bus.req_ready), 65'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Back-to-back full-word requests to words first..first+n-1.
  task automatic stream(input int first, input int n, input logic we);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 1000) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = BASE + 64'((first + i) * 8);
      bus.req_we    = we;
      bus.req_wdata = pat(first + i);
      bus.req_wstrb = 8'hFF;
      @(negedge clk);
      if (bus.req_ready) i++;
      else ready_drops++;
      @(posedge clk); #1;
      guard++;
    end
    bus.req_valid = 1'b0;
    check("stream_done", 65'(i), 65'(n));
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", 65'(exp_q.size()), 65'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int a0;
    int r0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_we     = 1'b0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
    bus.resp_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 65'(bus.req_ready), 65'd0);
    check("rst_resp_valid", 65'(bus.resp_valid), 65'd0);
    check("rst_resp_data", 65'(bus.resp_data), 65'd0);
    check("rst_resp_err", 65'(bus.resp_err), 65'd0);
    rst = 1'b1;
    #1;
    check("ready_before_edge", 65'(bus.req_ready), 65'd0);
    @(posedge clk); #1;
    check("ready_after_rst", 65'(bus.req_ready), 65'd1);

    // Reset then read: word 0 = 1, read back with two-cycle latency.
    do_req(BASE, 1'b1, 64'h1, 8'hFF);
    drain();
    do_req(BASE, 1'b0, 64'h0, 8'h00);
    drain();
    check("read0_data", last_resp, {64'h1, 1'b0});
    check("read0_latency", 65'(last_lat), 65'd2);

    // Byte-masked write, then a wstrb=0 no-op write.
    do_req(BASE + 64'h8, 1'b1, 64'h0, 8'hFF);
    do_req(BASE + 64'h8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    do_req(BASE + 64'h8, 1'b0, 64'h0, 8'h00);
    drain();
    check("masked_read", last_resp, {64'h0000_0000_FFFF_FFFF, 1'b0});
    do_req(BASE + 64'h8, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
    do_req(BASE + 64'h8, 1'b0, 64'h0, 8'h00);
    drain();
    check("noop_write_read", last_resp, {64'h0000_0000_FFFF_FFFF, 1'b0});

    // Error cases: misaligned, below base, one past the end.
    do_req(64'h1004, 1'b0, 64'h0, 8'h00);
    do_req(64'h0FF8, 1'b0, 64'h0, 8'h00);
    do_req(BASE + 64'(DEPTH * 8), 1'b0, 64'h0, 8'h00);
    drain();
    check("err_end_resp", last_resp, {64'h0, 1'b1});
    do_req(64'h1004, 1'b1, 64'h5555_5555_5555_5555, 8'hFF);
    do_req(64'h0FF8, 1'b1, 64'h5555_5555_5555_5555, 8'hFF);
    do_req(BASE, 1'b0, 64'h0, 8'h00);
    drain();
    check("err_mem_unchanged", last_resp, {64'h1, 1'b0});

    // Backpressure: only FDEPTH requests accepted while resp_ready is low.
    stream(16, 6, 1'b1);
    drain();
    bus.resp_ready = 1'b0;
    a0 = acc_cnt;
    fork
      stream(16, 6, 1'b0);
      begin
        repeat (10) @(posedge clk);
        #1;
        check("bp_accepted", 65'(acc_cnt - a0), 65'(FDEPTH));
        check("bp_req_ready", 65'(bus.req_ready), 65'd0);
        check("bp_resp_valid", 65'(bus.resp_valid), 65'd1);
        bus.resp_ready = 1'b1;
      end
    join
    drain();
    check("bp_total", 65'(acc_cnt - a0), 65'd6);

    // Streaming: 100 reads, one accept and one response per cycle.
    stream(100, 100, 1'b1);
    drain();
    ready_drops = 0;
    min_lat = 1000;
    max_lat = 0;
    r0 = resp_cnt;
    stream(100, 100, 1'b0);
    check("stream_ready_drops", 65'(ready_drops), 65'd0);
    drain();
    check("stream_resp_count", 65'(resp_cnt - r0), 65'd100);
    check("stream_min_lat", 65'(min_lat), 65'd2);
    check("stream_max_lat", 65'(max_lat), 65'd2);

    // Reset with three requests outstanding.
    bus.resp_ready = 1'b0;
    stream(100, 3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_resp_valid", 65'(bus.resp_valid), 65'd1);
    rst = 1'b0;
    #1;
    check("midrst_resp_valid", 65'(bus.resp_valid), 65'd0);
    check("midrst_req_ready", 65'(bus.req_ready), 65'd0);
    exp_q.delete();
    acc_q.delete();
    exp_reads  = 0;
    exp_writes = 0;
    exp_errs   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.resp_ready = 1'b1;
    r0 = resp_cnt;
    @(posedge clk); #1;
    check("post_rst_req_ready", 65'(bus.req_ready), 65'd1);
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_no_resp", 65'(resp_cnt - r0), 65'd0);
    do_req(BASE + 64'(150 * 8), 1'b0, 64'h0, 8'h00);
    do_req(64'h1004, 1'b0, 64'h0, 8'h00);
    do_req(BASE + 64'h10, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0);
    drain();
    check("post_rst_read", 65'(resp_cnt - r0), 65'd3);

`ifdef IMEM_RESPONDER_STATS_EN
    check("stat_reads", 65'(stat_reads), 65'(exp_reads));
    check("stat_writes", 65'(stat_writes), 65'(exp_writes));
    check("stat_errs", 65'(stat_errs), 65'(exp_errs));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
